// File: rtl/addr_decoder_pkg.sv
// Shared definitions for the Dock address decoder configuration bank.
// Contents:
//   - address-map offset helpers, functions of (addr_w, num_win)
//   - CTRL write-bit indices and STATUS bit layout
//   - commit FSM state enum
//   - top-byte valid-bit mask helper for address widths that are not byte multiples
package addr_decoder_pkg;

  typedef enum logic [0:0] {
    CS_IDLE = 1'b0,
    CS_WAIT = 1'b1
  } commit_state_e;

  // CTRL write bits
  localparam int unsigned CTRL_COMMIT_BIT  = 0;
  localparam int unsigned CTRL_DISCARD_BIT = 1;
  localparam int unsigned CTRL_LOCK_BIT    = 7;

  // STATUS read layout: {5'b0, locked, dirty, commit_busy}
  localparam int unsigned STAT_BUSY_BIT   = 0;
  localparam int unsigned STAT_DIRTY_BIT  = 1;
  localparam int unsigned STAT_LOCKED_BIT = 2;

  localparam int unsigned BASE_OFF = 0;

  function automatic int unsigned cfg_bytes(int unsigned addr_w);
    return (addr_w + 7) / 8;
  endfunction

  function automatic int unsigned mask_off(int unsigned addr_w, int unsigned num_win);
    return num_win * cfg_bytes(addr_w);
  endfunction

  function automatic int unsigned slot_off(int unsigned addr_w, int unsigned num_win);
    return 2 * num_win * cfg_bytes(addr_w);
  endfunction

  function automatic int unsigned op_off(int unsigned addr_w, int unsigned num_win);
    return slot_off(addr_w, num_win) + num_win;
  endfunction

  function automatic int unsigned ctrl_off(int unsigned addr_w, int unsigned num_win);
    return op_off(addr_w, num_win) + num_win;
  endfunction

  function automatic int unsigned status_off(int unsigned addr_w, int unsigned num_win);
    return ctrl_off(addr_w, num_win) + 1;
  endfunction

  // Valid bits in the most significant BASE/MASK byte; bits above addr_w are dropped.
  function automatic logic [7:0] top_byte_mask(int unsigned addr_w);
    return 8'hFF >> ((8 - (addr_w % 8)) % 8);
  endfunction

endpackage

// File: rtl/addr_decoder_cfg_commit_fsm.sv
// Commit sequencer for the address decoder configuration bank.
// Holds the IDLE/WAIT state, the completed-commit generation counter and the apply strobe.
// The apply strobe is high during the cycle whose closing edge copies shadow to active.
// Ports:
//   clk, rst_n    bank clock, async active-low reset
//   commit_req    accepted COMMIT write (only meaningful in CS_IDLE)
//   dec_idle      decoder has no transaction in flight
//   commit_busy   commit pending (state is CS_WAIT)
//   apply         copy shadow to active at the next edge
//   gen           completed-commit count, wraps
module addr_decoder_cfg_commit_fsm
  import addr_decoder_pkg::*;
#(
  parameter int unsigned GEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             commit_req,
  input  logic             dec_idle,
  output logic             commit_busy,
  output logic             apply,
  output logic [GEN_W-1:0] gen
);

  commit_state_e    state_q, state_d;
  logic [GEN_W-1:0] gen_q, gen_d;

  always_comb begin
    state_d = state_q;
    gen_d   = gen_q;
    apply   = 1'b0;
    case (state_q)
      CS_IDLE: begin
        if (commit_req) state_d = CS_WAIT;
      end
      CS_WAIT: begin
        // No timeout: hold until the decoder drains.
        if (dec_idle) begin
          apply   = 1'b1;
          gen_d   = gen_q + 1'b1;
          state_d = CS_IDLE;
        end
      end
      default: state_d = CS_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CS_IDLE;
      gen_q   <= '0;
    end else begin
      state_q <= state_d;
      gen_q   <= gen_d;
    end
  end

  assign commit_busy = (state_q == CS_WAIT);
  assign gen         = gen_q;

endmodule

// File: rtl/addr_decoder_cfg_bank.sv
// Double-buffered configuration bank for the Dock address decoder.
// Config-bus byte writes stage BASE/MASK/SLOT/OP window entries in a shadow bank; a CTRL
// COMMIT copies the whole shadow bank into the active bank once the decoder reports idle.
// The active bank drives the flattened match tables.
// Build option: define ADDR_DECODER_CFG_READBACK_EN to read shadow table bytes back; without
// it those reads return 0 (STATUS readback is always present).
// Ports:
//   cfg_clk, cfg_rst_n                      clock, async active-low reset
//   cfg_req/cfg_we/cfg_addr/cfg_wdata       byte access request
//   cfg_ack/cfg_err/cfg_rdata               registered response, one cycle after the request
//   dec_idle                                decoder has no transaction in flight
//   commit_busy, cfg_gen                    commit pending, completed-commit count
//   base_flat/mask_flat/slot_flat/op_flat   active tables, window w at slice w
module addr_decoder_cfg_bank
  import addr_decoder_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned NUM_WIN = 16,
  parameter int unsigned SLOT_W  = 3,
  parameter int unsigned CFG_AW  = 8,
  parameter int unsigned GEN_W   = 8
) (
  input  logic                      cfg_clk,
  input  logic                      cfg_rst_n,
  input  logic                      cfg_req,
  input  logic                      cfg_we,
  input  logic [CFG_AW-1:0]         cfg_addr,
  input  logic [7:0]                cfg_wdata,
  output logic                      cfg_ack,
  output logic                      cfg_err,
  output logic [7:0]                cfg_rdata,
  input  logic                      dec_idle,
  output logic                      commit_busy,
  output logic [GEN_W-1:0]          cfg_gen,
  output logic [NUM_WIN*ADDR_W-1:0] base_flat,
  output logic [NUM_WIN*ADDR_W-1:0] mask_flat,
  output logic [NUM_WIN*SLOT_W-1:0] slot_flat,
  output logic [NUM_WIN*8-1:0]      op_flat
);

  localparam int unsigned CFG_BYTES  = cfg_bytes(ADDR_W);
  localparam int unsigned PAD_W      = CFG_BYTES * 8;
  localparam int unsigned MASK_OFF   = mask_off(ADDR_W, NUM_WIN);
  localparam int unsigned SLOT_OFF   = slot_off(ADDR_W, NUM_WIN);
  localparam int unsigned OP_OFF     = op_off(ADDR_W, NUM_WIN);
  localparam int unsigned CTRL_OFF   = ctrl_off(ADDR_W, NUM_WIN);
  localparam int unsigned STATUS_OFF = status_off(ADDR_W, NUM_WIN);
  localparam int unsigned WIN_IW     = (NUM_WIN > 1) ? $clog2(NUM_WIN) : 1;
  localparam int unsigned BYTE_IW    = (CFG_BYTES > 1) ? $clog2(CFG_BYTES) : 1;
  localparam logic [7:0]  TOP_MASK   = top_byte_mask(ADDR_W);

  // Base/mask entries are byte-padded; padding bits are never written so they stay 0.
  logic [NUM_WIN-1:0][PAD_W-1:0]  base_sh_q, base_act_q;
  logic [NUM_WIN-1:0][PAD_W-1:0]  mask_sh_q, mask_act_q;
  logic [NUM_WIN-1:0][SLOT_W-1:0] slot_sh_q, slot_act_q;
  logic [NUM_WIN-1:0][7:0]        op_sh_q, op_act_q;
  logic                           dirty_q, dirty_d;
  logic                           locked_q, locked_d;
  logic                           ack_q, err_q, err_d;
  logic [7:0]                     rdata_q, rdata_d;

  logic                           apply;
  logic                           commit_req;

  int unsigned                    addr_u;
  int unsigned                    tbl_off;
  logic                           in_base, in_mask, in_slot, in_op, is_ctrl, is_status, oor;
  logic                           in_table;
  logic [WIN_IW-1:0]              win_tbl, win_so;
  logic [BYTE_IW-1:0]             byte_sel;
  logic [7:0]                     wbyte;
  logic                           sh_wr, ctrl_wr, discard;
  logic [7:0]                     status_vec;

  addr_decoder_cfg_commit_fsm #(
    .GEN_W (GEN_W)
  ) u_commit_fsm (
    .clk         (cfg_clk),
    .rst_n       (cfg_rst_n),
    .commit_req  (commit_req),
    .dec_idle    (dec_idle),
    .commit_busy (commit_busy),
    .apply       (apply),
    .gen         (cfg_gen)
  );

  // Address decode
  always_comb begin
    addr_u    = 32'(cfg_addr);
    in_base   = (addr_u < MASK_OFF);
    in_mask   = (addr_u >= MASK_OFF) && (addr_u < SLOT_OFF);
    in_slot   = (addr_u >= SLOT_OFF) && (addr_u < OP_OFF);
    in_op     = (addr_u >= OP_OFF) && (addr_u < CTRL_OFF);
    is_ctrl   = (addr_u == CTRL_OFF);
    is_status = (addr_u == STATUS_OFF);
    oor       = (addr_u > STATUS_OFF);
    in_table  = in_base | in_mask | in_slot | in_op;
    tbl_off   = in_mask ? (addr_u - MASK_OFF) : (addr_u - BASE_OFF);
    win_tbl   = WIN_IW'(tbl_off / CFG_BYTES);
    byte_sel  = BYTE_IW'(tbl_off % CFG_BYTES);
    win_so    = in_op ? WIN_IW'(addr_u - OP_OFF) : WIN_IW'(addr_u - SLOT_OFF);
    wbyte     = cfg_wdata & ((32'(byte_sel) == CFG_BYTES - 1) ? TOP_MASK : 8'hFF);
  end

  // Access qualification and side effects
  always_comb begin
    err_d = 1'b0;
    if (cfg_req) begin
      if (oor) begin
        err_d = 1'b1;
      end else if (cfg_we) begin
        // STATUS is read-only; nothing may be written while locked or while a commit waits.
        if (locked_q || commit_busy || is_status) begin
          err_d = 1'b1;
        end else if (is_ctrl && cfg_wdata[CTRL_COMMIT_BIT] && cfg_wdata[CTRL_DISCARD_BIT]) begin
          err_d = 1'b1;
        end
      end
    end

    sh_wr      = cfg_req && cfg_we && !err_d && in_table;
    ctrl_wr    = cfg_req && cfg_we && !err_d && is_ctrl;
    discard    = ctrl_wr && cfg_wdata[CTRL_DISCARD_BIT];
    // A COMMIT with nothing staged is acked but does not start a commit.
    commit_req = ctrl_wr && cfg_wdata[CTRL_COMMIT_BIT] && dirty_q;

    locked_d = locked_q | (ctrl_wr && cfg_wdata[CTRL_LOCK_BIT]);
    dirty_d  = dirty_q;
    if (apply || discard) begin
      dirty_d = 1'b0;
    end else if (sh_wr) begin
      dirty_d = 1'b1;
    end
  end

  // Read mux
  always_comb begin
    status_vec                  = '0;
    status_vec[STAT_BUSY_BIT]   = commit_busy;
    status_vec[STAT_DIRTY_BIT]  = dirty_q;
    status_vec[STAT_LOCKED_BIT] = locked_q;
    rdata_d                     = '0;
    if (cfg_req && !cfg_we) begin
      if (is_status) begin
        rdata_d = status_vec;
      end
`ifdef ADDR_DECODER_CFG_READBACK_EN
      else if (in_base) begin
        rdata_d = base_sh_q[win_tbl][{byte_sel, 3'b000} +: 8];
      end else if (in_mask) begin
        rdata_d = mask_sh_q[win_tbl][{byte_sel, 3'b000} +: 8];
      end else if (in_slot) begin
        rdata_d = 8'(slot_sh_q[win_so]);
      end else if (in_op) begin
        rdata_d = op_sh_q[win_so];
      end
`endif
    end
  end

  always_ff @(posedge cfg_clk or negedge cfg_rst_n) begin
    if (!cfg_rst_n) begin
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      dirty_q  <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      ack_q    <= cfg_req;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      dirty_q  <= dirty_d;
      locked_q <= locked_d;
    end
  end

  // Shadow and active banks; op resets to all-ones (every op allowed) per window.
  always_ff @(posedge cfg_clk or negedge cfg_rst_n) begin
    if (!cfg_rst_n) begin
      base_sh_q  <= '0;
      mask_sh_q  <= '0;
      slot_sh_q  <= '0;
      op_sh_q    <= '1;
      base_act_q <= '0;
      mask_act_q <= '0;
      slot_act_q <= '0;
      op_act_q   <= '1;
    end else begin
      if (apply) begin
        base_act_q <= base_sh_q;
        mask_act_q <= mask_sh_q;
        slot_act_q <= slot_sh_q;
        op_act_q   <= op_sh_q;
      end
      if (discard) begin
        base_sh_q <= base_act_q;
        mask_sh_q <= mask_act_q;
        slot_sh_q <= slot_act_q;
        op_sh_q   <= op_act_q;
      end else if (sh_wr) begin
        if (in_base) base_sh_q[win_tbl][{byte_sel, 3'b000} +: 8] <= wbyte;
        if (in_mask) mask_sh_q[win_tbl][{byte_sel, 3'b000} +: 8] <= wbyte;
        if (in_slot) slot_sh_q[win_so] <= cfg_wdata[SLOT_W-1:0];
        if (in_op)   op_sh_q[win_so]   <= cfg_wdata;
      end
    end
  end

  for (genvar w = 0; w < NUM_WIN; w++) begin : g_flat
    assign base_flat[w*ADDR_W +: ADDR_W] = base_act_q[w][ADDR_W-1:0];
    assign mask_flat[w*ADDR_W +: ADDR_W] = mask_act_q[w][ADDR_W-1:0];
    assign slot_flat[w*SLOT_W +: SLOT_W] = slot_act_q[w];
    assign op_flat[w*8 +: 8]             = op_act_q[w];
  end

  assign cfg_ack   = ack_q;
  assign cfg_err   = err_q;
  assign cfg_rdata = rdata_q;

endmodule

// File: tb/tb_addr_decoder_cfg_bank.sv
// Directed bench for addr_decoder_cfg_bank with default parameters.
// Address map for ADDR_W=32, NUM_WIN=16: BASE 0, MASK 64, SLOT 128, OP 144, CTRL 160, STATUS 161.
module tb_addr_decoder_cfg_bank;

  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned NUM_WIN    = 16;
  localparam int unsigned SLOT_W     = 3;
  localparam int unsigned CFG_AW     = 8;
  localparam int unsigned GEN_W      = 8;
  localparam int unsigned SLOT_OFF   = 128;
  localparam int unsigned OP_OFF     = 144;
  localparam int unsigned CTRL_OFF   = 160;
  localparam int unsigned STATUS_OFF = 161;

`ifdef ADDR_DECODER_CFG_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic                      cfg_clk = 1'b0;
  logic                      cfg_rst_n = 1'b0;
  logic                      cfg_req = 1'b0;
  logic                      cfg_we = 1'b0;
  logic [CFG_AW-1:0]         cfg_addr = '0;
  logic [7:0]                cfg_wdata = '0;
  logic                      cfg_ack, cfg_err;
  logic [7:0]                cfg_rdata;
  logic                      dec_idle = 1'b1;
  logic                      commit_busy;
  logic [GEN_W-1:0]          cfg_gen;
  logic [NUM_WIN*ADDR_W-1:0] base_flat, mask_flat;
  logic [NUM_WIN*SLOT_W-1:0] slot_flat;
  logic [NUM_WIN*8-1:0]      op_flat;

  int n_checks = 0;
  int n_fail = 0;

  logic       a_ack, a_err;
  logic [7:0] a_rdata;

  addr_decoder_cfg_bank #(
    .ADDR_W  (ADDR_W),
    .NUM_WIN (NUM_WIN),
    .SLOT_W  (SLOT_W),
    .CFG_AW  (CFG_AW),
    .GEN_W   (GEN_W)
  ) dut (
    .cfg_clk     (cfg_clk),
    .cfg_rst_n   (cfg_rst_n),
    .cfg_req     (cfg_req),
    .cfg_we      (cfg_we),
    .cfg_addr    (cfg_addr),
    .cfg_wdata   (cfg_wdata),
    .cfg_ack     (cfg_ack),
    .cfg_err     (cfg_err),
    .cfg_rdata   (cfg_rdata),
    .dec_idle    (dec_idle),
    .commit_busy (commit_busy),
    .cfg_gen     (cfg_gen),
    .base_flat   (base_flat),
    .mask_flat   (mask_flat),
    .slot_flat   (slot_flat),
    .op_flat     (op_flat)
  );

  always #5 cfg_clk = ~cfg_clk;

  // One access: driven at negedge, sampled at the next posedge, response captured 1ns later.
  task automatic access(input logic we, input int unsigned addr, input logic [7:0] wdata);
    @(negedge cfg_clk);
    cfg_req   = 1'b1;
    cfg_we    = we;
    cfg_addr  = CFG_AW'(addr);
    cfg_wdata = wdata;
    @(posedge cfg_clk);
    #1;
    a_ack   = cfg_ack;
    a_err   = cfg_err;
    a_rdata = cfg_rdata;
    cfg_req = 1'b0;
    cfg_we  = 1'b0;
  endtask

  task automatic test_reset();
    cfg_rst_n = 1'b0;
    repeat (2) @(posedge cfg_clk);
    #1;
    n_checks++;
    if (op_flat !== {NUM_WIN{8'hFF}}) begin
      n_fail++; $display("FAIL reset_op: got %h expected all FF", op_flat);
    end
    n_checks++;
    if ({base_flat, mask_flat, slot_flat} !== '0) begin
      n_fail++; $display("FAIL reset_tables: base/mask/slot not zero, got base %h", base_flat);
    end
    n_checks++;
    if ({cfg_gen, commit_busy, cfg_ack, cfg_err, cfg_rdata} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got gen %h busy %b ack %b err %b rdata %h expected 0",
                         cfg_gen, commit_busy, cfg_ack, cfg_err, cfg_rdata);
    end
    @(negedge cfg_clk);
    cfg_rst_n = 1'b1;
    access(1'b0, STATUS_OFF, 8'h00);
    n_checks++;
    if (a_ack !== 1'b1 || a_err !== 1'b0 || a_rdata !== 8'h00) begin
      n_fail++; $display("FAIL reset_status: got ack %b err %b data %h expected 1 0 00",
                         a_ack, a_err, a_rdata);
    end
  endtask

  task automatic test_shadow_write();
    logic [7:0] bytes [4];
    logic       bad;
    bytes = '{8'h00, 8'h10, 8'h00, 8'h80};
    bad = 1'b0;
    for (int b = 0; b < 4; b++) begin
      access(1'b1, 8 + b, bytes[b]);
      if (a_ack !== 1'b1 || a_err !== 1'b0) bad = 1'b1;
    end
    n_checks++;
    if (bad) begin
      n_fail++; $display("FAIL shadow_write_ack: got last ack %b err %b expected 1 0", a_ack, a_err);
    end
    n_checks++;
    if (base_flat[95:64] !== 32'h0) begin
      n_fail++; $display("FAIL shadow_not_active: got %h expected 00000000", base_flat[95:64]);
    end
    access(1'b0, STATUS_OFF, 8'h00);
    n_checks++;
    if (a_rdata !== 8'h02) begin
      n_fail++; $display("FAIL status_dirty: got %h expected 02", a_rdata);
    end
    access(1'b0, 9, 8'h00);
    n_checks++;
    if (a_ack !== 1'b1 || a_err !== 1'b0 || a_rdata !== (RB ? 8'h10 : 8'h00)) begin
      n_fail++; $display("FAIL base_readback: got ack %b err %b data %h expected 1 0 %h",
                         a_ack, a_err, a_rdata, RB ? 8'h10 : 8'h00);
    end
  endtask

  task automatic test_commit_wait();
    int busy_cnt;
    bit fell;
    busy_cnt = 0;
    fell     = 1'b0;
    dec_idle = 1'b0;
    access(1'b1, CTRL_OFF, 8'h01);
    n_checks++;
    if (a_err !== 1'b0 || commit_busy !== 1'b1) begin
      n_fail++; $display("FAIL commit_start: got err %b busy %b expected 0 1", a_err, commit_busy);
    end
    if (commit_busy) busy_cnt++;
    access(1'b1, 8, 8'h55);
    n_checks++;
    if (a_ack !== 1'b1 || a_err !== 1'b1) begin
      n_fail++; $display("FAIL wait_write_err: got ack %b err %b expected 1 1", a_ack, a_err);
    end
    if (commit_busy) busy_cnt++;
    access(1'b0, 9, 8'h00);
    n_checks++;
    if (a_ack !== 1'b1 || a_err !== 1'b0 || a_rdata !== (RB ? 8'h10 : 8'h00)) begin
      n_fail++; $display("FAIL wait_read: got ack %b err %b data %h", a_ack, a_err, a_rdata);
    end
    if (commit_busy) busy_cnt++;
    repeat (3) begin
      @(posedge cfg_clk);
      #1;
      if (commit_busy) busy_cnt++;
    end
    n_checks++;
    if (base_flat[95:64] !== 32'h0) begin
      n_fail++; $display("FAIL wait_active_held: got %h expected 00000000", base_flat[95:64]);
    end
    @(negedge cfg_clk);
    dec_idle = 1'b1;
    for (int i = 0; i < 10 && !fell; i++) begin
      @(posedge cfg_clk);
      #1;
      if (commit_busy) busy_cnt++;
      else fell = 1'b1;
    end
    n_checks++;
    if (!fell || busy_cnt != 6) begin
      n_fail++; $display("FAIL commit_busy_len: got %0d cycles (fell %b) expected 6", busy_cnt, fell);
    end
    n_checks++;
    if (base_flat[95:64] !== 32'h8000_1000 || cfg_gen !== 8'd1) begin
      n_fail++; $display("FAIL commit_apply: got base %h gen %0d expected 80001000 1",
                         base_flat[95:64], cfg_gen);
    end
    access(1'b0, STATUS_OFF, 8'h00);
    n_checks++;
    if (a_rdata !== 8'h00) begin
      n_fail++; $display("FAIL commit_clears_dirty: got %h expected 00", a_rdata);
    end
  endtask

  task automatic test_discard();
    access(1'b1, SLOT_OFF, 8'hFD);  // only wdata[2:0] = 5 is kept
    access(1'b0, SLOT_OFF, 8'h00);
    n_checks++;
    if (a_rdata !== (RB ? 8'h05 : 8'h00)) begin
      n_fail++; $display("FAIL slot_shadow: got %h expected %h", a_rdata, RB ? 8'h05 : 8'h00);
    end
    access(1'b1, CTRL_OFF, 8'h02);
    n_checks++;
    if (a_ack !== 1'b1 || a_err !== 1'b0 || commit_busy !== 1'b0) begin
      n_fail++; $display("FAIL discard_ack: got ack %b err %b busy %b", a_ack, a_err, commit_busy);
    end
    access(1'b0, SLOT_OFF, 8'h00);
    n_checks++;
    if (a_rdata !== 8'h00) begin
      n_fail++; $display("FAIL discard_slot: got %h expected 00", a_rdata);
    end
    access(1'b0, STATUS_OFF, 8'h00);
    n_checks++;
    if (a_rdata !== 8'h00 || slot_flat !== '0) begin
      n_fail++; $display("FAIL discard_status: got status %h slot %h expected 00 0", a_rdata, slot_flat);
    end
  endtask

  task automatic test_ctrl_edge();
    access(1'b1, CTRL_OFF, 8'h01);  // clean shadow: acked, no commit
    @(posedge cfg_clk);
    #1;
    n_checks++;
    if (a_err !== 1'b0 || commit_busy !== 1'b0 || cfg_gen !== 8'd1) begin
      n_fail++; $display("FAIL clean_commit: got err %b busy %b gen %0d expected 0 0 1",
                         a_err, commit_busy, cfg_gen);
    end
    access(1'b1, CTRL_OFF, 8'h03);
    n_checks++;
    if (a_err !== 1'b1 || commit_busy !== 1'b0) begin
      n_fail++; $display("FAIL commit_discard_err: got err %b busy %b expected 1 0", a_err, commit_busy);
    end
    access(1'b0, CTRL_OFF, 8'h00);
    n_checks++;
    if (a_err !== 1'b0 || a_rdata !== 8'h00) begin
      n_fail++; $display("FAIL ctrl_read: got err %b data %h expected 0 00", a_err, a_rdata);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge cfg_clk);
    cfg_req = 1'b1; cfg_we = 1'b1; cfg_addr = CFG_AW'(OP_OFF + 1); cfg_wdata = 8'h3C;
    @(negedge cfg_clk);
    n_checks++;
    if (cfg_ack !== 1'b1 || cfg_err !== 1'b0) begin
      n_fail++; $display("FAIL b2b_op_write: got ack %b err %b expected 1 0", cfg_ack, cfg_err);
    end
    cfg_addr = CFG_AW'(127); cfg_wdata = 8'hA5;  // mask w15 byte 3
    @(negedge cfg_clk);
    n_checks++;
    if (cfg_ack !== 1'b1 || cfg_err !== 1'b0) begin
      n_fail++; $display("FAIL b2b_mask_write: got ack %b err %b expected 1 0", cfg_ack, cfg_err);
    end
    cfg_we = 1'b0; cfg_addr = CFG_AW'(OP_OFF + 1);
    @(negedge cfg_clk);
    n_checks++;
    if (cfg_ack !== 1'b1 || cfg_rdata !== (RB ? 8'h3C : 8'h00)) begin
      n_fail++; $display("FAIL b2b_read: got ack %b data %h expected 1 %h",
                         cfg_ack, cfg_rdata, RB ? 8'h3C : 8'h00);
    end
    cfg_req = 1'b0;
    dec_idle = 1'b1;
    access(1'b1, CTRL_OFF, 8'h01);
    n_checks++;
    if (commit_busy !== 1'b1) begin
      n_fail++; $display("FAIL b2b_commit_busy: got %b expected 1", commit_busy);
    end
    @(posedge cfg_clk);
    #1;
    n_checks++;
    if (commit_busy !== 1'b0 || op_flat[15:8] !== 8'h3C || op_flat[7:0] !== 8'hFF ||
        mask_flat[511:504] !== 8'hA5 || cfg_gen !== 8'd2) begin
      n_fail++; $display("FAIL b2b_apply: got busy %b op1 %h op0 %h mask15 %h gen %0d",
                         commit_busy, op_flat[15:8], op_flat[7:0], mask_flat[511:504], cfg_gen);
    end
  endtask

  task automatic test_range();
    access(1'b0, STATUS_OFF + 1, 8'h00);
    n_checks++;
    if (a_ack !== 1'b1 || a_err !== 1'b1 || a_rdata !== 8'h00) begin
      n_fail++; $display("FAIL oor_read: got ack %b err %b data %h expected 1 1 00",
                         a_ack, a_err, a_rdata);
    end
    access(1'b1, 255, 8'h12);
    n_checks++;
    if (a_err !== 1'b1) begin
      n_fail++; $display("FAIL oor_write: got err %b expected 1", a_err);
    end
    access(1'b1, STATUS_OFF, 8'h07);
    n_checks++;
    if (a_err !== 1'b1) begin
      n_fail++; $display("FAIL status_write: got err %b expected 1", a_err);
    end
  endtask

  task automatic test_reset_mid_wait();
    access(1'b1, 0, 8'hAA);
    dec_idle = 1'b0;
    access(1'b1, CTRL_OFF, 8'h01);
    @(posedge cfg_clk);
    #3;
    cfg_rst_n = 1'b0;
    #1;
    n_checks++;
    if (commit_busy !== 1'b0 || cfg_gen !== '0 || op_flat !== {NUM_WIN{8'hFF}} ||
        base_flat !== '0 || mask_flat !== '0) begin
      n_fail++; $display("FAIL reset_mid_wait: got busy %b gen %0d op %h", commit_busy, cfg_gen,
                         op_flat);
    end
    @(negedge cfg_clk);
    cfg_rst_n = 1'b1;
    dec_idle  = 1'b1;
    repeat (3) @(posedge cfg_clk);
    #1;
    n_checks++;
    if (commit_busy !== 1'b0 || base_flat[31:0] !== 32'h0) begin
      n_fail++; $display("FAIL reset_commit_lost: got busy %b base0 %h", commit_busy, base_flat[31:0]);
    end
    access(1'b0, STATUS_OFF, 8'h00);
    n_checks++;
    if (a_rdata !== 8'h00) begin
      n_fail++; $display("FAIL reset_mid_wait_status: got %h expected 00", a_rdata);
    end
  endtask

  task automatic test_gen_wrap();
    for (int i = 0; i < 256; i++) begin
      access(1'b1, SLOT_OFF + 3, 8'(i));
      access(1'b1, CTRL_OFF, 8'h01);
      @(posedge cfg_clk);
      #1;
      if (i == 254) begin
        n_checks++;
        if (cfg_gen !== 8'hFF) begin
          n_fail++; $display("FAIL gen_max: got %h expected ff", cfg_gen);
        end
      end
    end
    n_checks++;
    if (cfg_gen !== 8'h00 || slot_flat[11:9] !== 3'd7) begin
      n_fail++; $display("FAIL gen_wrap: got gen %h slot3 %0d expected 00 7", cfg_gen, slot_flat[11:9]);
    end
  endtask

  task automatic test_lock();
    access(1'b1, CTRL_OFF, 8'h80);
    n_checks++;
    if (a_err !== 1'b0) begin
      n_fail++; $display("FAIL lock_write: got err %b expected 0", a_err);
    end
    access(1'b0, STATUS_OFF, 8'h00);
    n_checks++;
    if (a_rdata !== 8'h04) begin
      n_fail++; $display("FAIL lock_status: got %h expected 04", a_rdata);
    end
    access(1'b1, 0, 8'h11);
    n_checks++;
    if (a_err !== 1'b1) begin
      n_fail++; $display("FAIL locked_table_write: got err %b expected 1", a_err);
    end
    access(1'b1, CTRL_OFF, 8'h02);
    n_checks++;
    if (a_err !== 1'b1) begin
      n_fail++; $display("FAIL locked_ctrl_write: got err %b expected 1", a_err);
    end
    access(1'b0, STATUS_OFF, 8'h00);
    n_checks++;
    if (a_err !== 1'b0 || a_rdata !== 8'h04) begin
      n_fail++; $display("FAIL locked_read: got err %b data %h expected 0 04", a_err, a_rdata);
    end
    @(negedge cfg_clk);
    cfg_rst_n = 1'b0;
    @(negedge cfg_clk);
    cfg_rst_n = 1'b1;
    access(1'b1, 0, 8'h11);
    n_checks++;
    if (a_err !== 1'b0) begin
      n_fail++; $display("FAIL lock_cleared: got err %b expected 0", a_err);
    end
  endtask

  initial begin
    test_reset();
    test_shadow_write();
    test_commit_wait();
    test_discard();
    test_ctrl_edge();
    test_back_to_back();
    test_range();
    test_reset_mid_wait();
    test_gen_wrap();
    test_lock();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
